mem_port_sched: RTL
===================

MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data/instruction width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum busy cycles waiting for mem_ready before abort.
REQ-004 SHALL have parameter DSTREAK, default 3, consecutive data grants allowed before a waiting fetch wins.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port if_req, input, 1, fetch request, held until if_done.
REQ-008 SHALL have port if_addr, input, ADDR_W, fetch address.
REQ-009 SHALL have port d_req, input, 1, load/store request, held until d_done.
REQ-010 SHALL have port d_we, input, 1, 1 = store (memwrite), 0 = load.
REQ-011 SHALL have ports d_addr (input, ADDR_W) and d_wdata (input, DATA_W), data address and store data.
REQ-012 SHALL have ports if_done and d_done, output, 1, one-cycle completion pulses.
REQ-013 SHALL have ports if_rdata and d_rdata, output, DATA_W, read data, valid while the matching done is high.
REQ-014 SHALL have port err, output, 1, pulses with done when the access timed out.
REQ-015 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), registered memory command.
REQ-016 SHALL have ports mem_rdata (input, DATA_W) and mem_ready (input, 1), memory response.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D.
REQ-018 SHALL, in IDLE with any request, select a winner, latch its address, we and wdata, and enter the BUSY state for it next cycle.
REQ-019 SHALL give d_req priority over if_req, except that if_req wins when streak counter equals DSTREAK.
REQ-020 SHALL increment the streak counter (saturating at DSTREAK) on each data grant and clear it on each fetch grant.
REQ-021 SHALL drive mem_en=1 with stable mem_addr/mem_we/mem_wdata for every BUSY cycle and mem_en=0 in IDLE; mem_we=0 for fetches.
REQ-022 SHALL, when mem_ready=1 in a BUSY cycle, capture mem_rdata, pulse the owner's done next cycle, and be in IDLE that same next cycle.
REQ-023 SHALL ignore mem_ready while in IDLE.
REQ-024 SHALL count BUSY cycles; when TIMEOUT cycles elapse without mem_ready, return to IDLE with done and err pulsed next cycle, rdata = 0.
REQ-025 SHALL give minimum latency of 3 cycles from request sampled in IDLE to done (mem_ready on first BUSY cycle), with one IDLE turnaround cycle between accesses.
REQ-026 SHALL complete an accepted access even if the requester drops req early; the done pulse is still issued.
REQ-027 SHALL never assert if_done and d_done in the same cycle.
REQ-028 SHALL hold if_rdata/d_rdata at their last captured value when not done.

Reset
REQ-029 SHALL, on reset asserted at any time including mid-access, force IDLE, streak=0, timeout counter=0, and all outputs 0, with no done or err issued for the aborted access.

Structure
REQ-030 SHALL place state encoding (IDLE/BUSY_IF/BUSY_D) and default parameter constants in the shared CPU package.
REQ-031 SHALL be a single module with no sub-modules; the FSM, streak counter and timeout counter are inline.

Verification
REQ-032 SHALL verify: if_req=1 if_addr=0x10 alone, mem_ready on first BUSY cycle, mem_rdata=0x1234 -> if_done at cycle 3 with if_rdata=0x1234, mem_we=0.
REQ-033 SHALL verify: if_req and d_req (store, d_addr=0x20, d_wdata=0xBEEF) simultaneously -> data served first with mem_we=1, mem_addr=0x20, mem_wdata=0xBEEF; fetch served next.
REQ-034 SHALL verify: d_req held continuously with if_req pending -> exactly 3 data grants, then one fetch grant, then data again.
REQ-035 SHALL verify: mem_ready never asserted -> after 15 BUSY cycles d_done=1 and err=1 together, d_rdata=0, FSM back in IDLE.
REQ-036 SHALL verify: reset asserted on second BUSY cycle -> mem_en=0 immediately, no done pulse afterwards, next request proceeds normally.
REQ-037 SHALL verify: mem_ready=1 while IDLE with no requests -> no done, no state change.

Source files
------------

// File: rtl/mem_port_sched_pkg.sv
// Shared constants for the memory port scheduler: FSM state encoding and
// default parameter values.
package mem_port_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_DSTREAK = 3;

endpackage

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler arbitrating instruction fetch and data accesses,
// with a data-streak limit for fetch fairness and a busy timeout abort.
module mem_port_sched
  import mem_port_sched_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DSTREAK = DEF_DSTREAK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              if_done,
  output logic              d_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(DSTREAK + 2);

  logic [1:0]        state_q,     state_d;
  logic [SW-1:0]     streak_q,    streak_d;
  logic [TW-1:0]     tcnt_q,      tcnt_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q,   if_done_d;
  logic              d_done_q,    d_done_d;
  logic              err_q,       err_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

  logic              fetch_turn_s;
  logic              finish_s;
  logic              timeout_s;
  logic [DATA_W-1:0] result_s;

  assign fetch_turn_s = if_req && (streak_q == SW'(DSTREAK));
  assign timeout_s    = (tcnt_q == TW'(TIMEOUT - 1));
  assign finish_s     = mem_ready || timeout_s;
  assign result_s     = mem_ready ? mem_rdata : '0;

  // Arbitration, memory command generation and completion tracking
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (d_req && !fetch_turn_s) begin
          state_d     = ST_BUSY_D;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          streak_d    = (streak_q == SW'(DSTREAK)) ? streak_q : streak_q + SW'(1);
        end else if (if_req) begin
          state_d     = ST_BUSY_IF;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end else begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (finish_s) begin
          state_d     = ST_IDLE;
          tcnt_d      = '0;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          err_d       = !mem_ready;
          if (state_q == ST_BUSY_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = result_s;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = result_s;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tcnt_d   = '0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      tcnt_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
